// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit: FSM states, funct3 codes
// and the access-legality check.
package lsu_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      RESP = 3'd4
   } lsu_state_t;

   localparam logic [2:0] F3_B         = 3'd0;
   localparam logic [2:0] F3_H         = 3'd1;
   localparam logic [2:0] F3_W         = 3'd2;
   localparam logic [2:0] F3_BU        = 3'd4;
   localparam logic [2:0] F3_HU        = 3'd5;
   localparam logic [2:0] DMEM_WORD_F3 = 3'b010;

   // Misaligned halves/words and unused funct3 codes are rejected before touching memory.
   function automatic logic access_fault(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
      logic fault;
      fault = 1'b1;
      if (we) begin
         case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = off[0];
            F3_W:    fault = |off;
            default: fault = 1'b1;
         endcase
      end else begin
         case (funct3)
            F3_B, F3_BU: fault = 1'b0;
            F3_H, F3_HU: fault = off[0];
            F3_W:        fault = |off;
            default:     fault = 1'b1;
         endcase
      end
      return fault;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: extracts and extends a byte/half/word from a memory word,
// and merges store data into the addressed lane of a word for read-modify-write.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] load_data,
   output logic [31:0] merged
);

   logic signed [7:0]  byte_s;
   logic signed [15:0] half_s;

   always_comb begin
      byte_s    = word[{off, 3'b000} +: 8];
      half_s    = word[{off[1], 4'b0000} +: 16];
      load_data = 32'd0;
      case (funct3)
         F3_B:    load_data = 32'(byte_s);
         F3_H:    load_data = 32'(half_s);
         F3_W:    load_data = word;
         F3_BU:   load_data = {24'd0, byte_s};
         F3_HU:   load_data = {16'd0, half_s};
         default: load_data = 32'd0;
      endcase
   end

   always_comb begin
      merged = word;
      case (funct3)
         F3_B:    merged[{off, 3'b000} +: 8]     = wdata[7:0];
         F3_H:    merged[{off[1], 4'b0000} +: 16] = wdata[15:0];
         F3_W:    merged = wdata;
         default: merged = word;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I data-side load/store unit: word-only dmem access, sub-word RMW stores, fault detection.
// Optional performance counters are built when LSU_PERF_CNT_EN is defined.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DMEM_RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic [4:0]  resp_rd,
   output logic        resp_fault,
   output logic        dmem_wren,
   output logic [2:0]  dmem_funct3,
   output logic [31:0] dmem_address,
   output logic [31:0] dmem_data_in,
   input  logic [31:0] dmem_data_out,
   output logic [31:0] perf_loads,
   output logic [31:0] perf_stores,
   output logic [31:0] perf_faults
);

   localparam int CNT_W = (DMEM_RD_LAT > 1) ? $clog2(DMEM_RD_LAT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(DMEM_RD_LAT - 1);

   lsu_state_t       state;
   logic [CNT_W-1:0] wait_cnt;
   logic             accept;

   logic             op_we_p0;
   logic [2:0]       op_funct3_p0;
   logic [1:0]       op_off_p0;
   logic [31:0]      op_wdata_p0;
   logic [4:0]       op_rd_p0;

   logic [31:0]      load_data;
   logic [31:0]      merged;

   assign accept      = req_valid && req_ready;
   assign dmem_funct3 = DMEM_WORD_F3;

   // Request capture: datapath fields only, held for the whole transaction
   always_ff @(posedge clk) begin
      if (accept) begin
         op_we_p0     <= req_we;
         op_funct3_p0 <= req_funct3;
         op_off_p0    <= req_addr[1:0];
         op_wdata_p0  <= req_wdata;
         op_rd_p0     <= req_rd;
      end
   end

   lsu_lane_align u_lane_align (
      .word      (dmem_data_out),
      .wdata     (op_wdata_p0),
      .off       (op_off_p0),
      .funct3    (op_funct3_p0),
      .load_data (load_data),
      .merged    (merged)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         req_ready    <= 1'b1;
         resp_valid   <= 1'b0;
         resp_fault   <= 1'b0;
         resp_rdata   <= 32'd0;
         resp_rd      <= 5'd0;
         dmem_wren    <= 1'b0;
         dmem_address <= 32'd0;
         dmem_data_in <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  if (access_fault(req_we, req_funct3, req_addr[1:0])) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= 32'd0;
                     resp_rd    <= req_rd;
                  end else begin
                     dmem_address <= {req_addr[31:2], 2'b00};
                     if (req_we && req_funct3 == F3_W) begin
                        // Full-word store needs no read
                        state        <= WR;
                        dmem_wren    <= 1'b1;
                        dmem_data_in <= req_wdata;
                     end else begin
                        state <= RD;
                     end
                  end
               end
            end
            RD: begin
               wait_cnt <= '0;
               state    <= WAIT;
            end
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  if (op_we_p0) begin
                     state        <= WR;
                     dmem_wren    <= 1'b1;
                     dmem_data_in <= merged;
                  end else begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b0;
                     resp_rdata <= load_data;
                     resp_rd    <= op_rd_p0;
                  end
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            WR: begin
               state      <= RESP;
               dmem_wren  <= 1'b0;
               resp_valid <= 1'b1;
               resp_fault <= 1'b0;
               resp_rdata <= 32'd0;
               resp_rd    <= op_rd_p0;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
               dmem_wren <= 1'b0;
            end
         endcase
      end
   end

`ifdef LSU_PERF_CNT_EN
   logic [31:0] cnt_loads, cnt_stores, cnt_faults;

   // Completion classification uses the still-held request fields during RESP
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_loads  <= 32'd0;
         cnt_stores <= 32'd0;
         cnt_faults <= 32'd0;
      end else if (resp_valid) begin
         if (resp_fault)    cnt_faults <= cnt_faults + 32'd1;
         else if (op_we_p0) cnt_stores <= cnt_stores + 32'd1;
         else               cnt_loads  <= cnt_loads + 32'd1;
      end
   end

   assign perf_loads  = cnt_loads;
   assign perf_stores = cnt_stores;
   assign perf_faults = cnt_faults;
`else
   assign perf_loads  = 32'd0;
   assign perf_stores = 32'd0;
   assign perf_faults = 32'd0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a one-cycle synchronous word memory.
module tb_load_store_unit;
   import lsu_pkg::*;

   localparam int LAT = 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [4:0]  req_rd;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_fault;
   logic        dmem_wren;
   logic [2:0]  dmem_funct3;
   logic [31:0] dmem_address;
   logic [31:0] dmem_data_in;
   logic [31:0] dmem_data_out;
   logic [31:0] perf_loads, perf_stores, perf_faults;

   logic [31:0] mem [0:255];

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } exp_t;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [31:0] rdata;
      logic        fault;
      int          lat;
   } req_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (dmem_wren) mem[dmem_address[9:2]] <= dmem_data_in;
      dmem_data_out <= mem[dmem_address[9:2]];
   end

   load_store_unit #(.DMEM_RD_LAT(LAT)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_we        (req_we),
      .req_funct3    (req_funct3),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_rd        (req_rd),
      .resp_valid    (resp_valid),
      .resp_rdata    (resp_rdata),
      .resp_rd       (resp_rd),
      .resp_fault    (resp_fault),
      .dmem_wren     (dmem_wren),
      .dmem_funct3   (dmem_funct3),
      .dmem_address  (dmem_address),
      .dmem_data_in  (dmem_data_in),
      .dmem_data_out (dmem_data_out),
      .perf_loads    (perf_loads),
      .perf_stores   (perf_stores),
      .perf_faults   (perf_faults)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one request, wait for its response, compare against the scoreboard entry.
   task automatic issue(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input logic [31:0] exp_rdata, input logic exp_fault, input int exp_lat,
                        input int exp_wren);
      int   n;
      int   wren_seen;
      exp_t e;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      req_rd     = rd;
      sb.push_back('{rd: rd, rdata: exp_rdata, fault: exp_fault, lat: exp_lat});
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 1;
      wren_seen = 0;
      while (!resp_valid && n < 30) begin
         wren_seen += int'(dmem_wren);
         @(posedge clk); #1; n++;
      end
      wren_seen += int'(dmem_wren);
      check({tag, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
      e = sb.pop_front();
      check({tag, ".latency"}, n, e.lat);
      check({tag, ".rd"}, {27'd0, resp_rd}, {27'd0, e.rd});
      check({tag, ".rdata"}, resp_rdata, e.rdata);
      check({tag, ".fault"}, {31'd0, resp_fault}, {31'd0, e.fault});
      check({tag, ".wren_cycles"}, wren_seen, exp_wren);
      @(posedge clk); #1;
      check({tag, ".pulse"}, {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      req_t seq[6];
      int   cyc, idx, nresp, next_acc, wren_seen;
      logic was_acc;
      exp_t e;

      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'd0;
      req_addr   = 32'd0;
      req_wdata  = 32'd0;
      req_rd     = 5'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.req_ready",  {31'd0, req_ready},  32'd1);
      check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst.resp_fault", {31'd0, resp_fault}, 32'd0);
      check("rst.resp_rdata", resp_rdata,          32'd0);
      check("rst.resp_rd",    {27'd0, resp_rd},    32'd0);
      check("rst.dmem_wren",  {31'd0, dmem_wren},  32'd0);
      check("rst.dmem_addr",  dmem_address,        32'd0);
      check("rst.dmem_din",   dmem_data_in,        32'd0);
      check("rst.dmem_f3",    {29'd0, dmem_funct3}, 32'd2);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Byte loads and extension
      issue("sw_pre", 1'b1, F3_W,  32'h100, 32'h8081_7F80, 5'd1, 32'd0, 1'b0, 2, 1);
      issue("lb100",  1'b0, F3_B,  32'h100, 32'd0, 5'd2, 32'hFFFF_FF80, 1'b0, 2 + LAT, 0);
      issue("lb101",  1'b0, F3_B,  32'h101, 32'd0, 5'd3, 32'h0000_007F, 1'b0, 2 + LAT, 0);
      issue("lb103",  1'b0, F3_B,  32'h103, 32'd0, 5'd4, 32'hFFFF_FF80, 1'b0, 2 + LAT, 0);
      issue("lbu103", 1'b0, F3_BU, 32'h103, 32'd0, 5'd5, 32'h0000_0080, 1'b0, 2 + LAT, 0);

      // Half and word loads
      issue("lh102",  1'b0, F3_H,  32'h102, 32'd0, 5'd6, 32'hFFFF_8081, 1'b0, 2 + LAT, 0);
      issue("lhu100", 1'b0, F3_HU, 32'h100, 32'd0, 5'd7, 32'h0000_7F80, 1'b0, 2 + LAT, 0);
      issue("lw100",  1'b0, F3_W,  32'h100, 32'd0, 5'd8, 32'h8081_7F80, 1'b0, 2 + LAT, 0);

      // Stores and read-modify-write merges
      issue("sw200",  1'b1, F3_W,  32'h200, 32'hDEAD_BEEF, 5'd9,  32'd0, 1'b0, 2, 1);
      issue("sb201",  1'b1, F3_B,  32'h201, 32'hFFFF_FF55, 5'd10, 32'd0, 1'b0, 3 + LAT, 1);
      issue("lw200a", 1'b0, F3_W,  32'h200, 32'd0, 5'd11, 32'hDEAD_55EF, 1'b0, 2 + LAT, 0);
      issue("sh202",  1'b1, F3_H,  32'h202, 32'hABCD_1234, 5'd12, 32'd0, 1'b0, 3 + LAT, 1);
      issue("lw200b", 1'b0, F3_W,  32'h200, 32'd0, 5'd13, 32'h1234_55EF, 1'b0, 2 + LAT, 0);

      // Faults: no memory access, immediate response
      issue("f_lw202", 1'b0, F3_W,  32'h202, 32'd0, 5'd14, 32'd0, 1'b1, 1, 0);
      issue("f_sh203", 1'b1, F3_H,  32'h203, 32'h1111_1111, 5'd15, 32'd0, 1'b1, 1, 0);
      issue("f_lb_f3", 1'b0, 3'd3,  32'h100, 32'd0, 5'd16, 32'd0, 1'b1, 1, 0);
      issue("f_st_f3", 1'b1, 3'd4,  32'h100, 32'd0, 5'd17, 32'd0, 1'b1, 1, 0);
      issue("f_lhu",   1'b0, F3_HU, 32'h101, 32'd0, 5'd18, 32'd0, 1'b1, 1, 0);
      check("mem100_intact", mem[8'h40], 32'h8081_7F80);

      // Reset asserted while an SB sits in WAIT
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F3_B;
      req_addr   = 32'h201;
      req_wdata  = 32'h0000_00AA;
      req_rd     = 5'd19;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wren_seen = int'(dmem_wren) + int'(resp_valid);
      @(posedge clk); #1;
      wren_seen += int'(dmem_wren) + int'(resp_valid);
      reset_n = 1'b0;
      #1;
      check("rstmid.wren_async",  {31'd0, dmem_wren}, 32'd0);
      check("rstmid.ready_async", {31'd0, req_ready}, 32'd1);
      repeat (3) begin
         @(posedge clk); #1;
         wren_seen += int'(dmem_wren) + int'(resp_valid);
      end
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         wren_seen += int'(dmem_wren) + int'(resp_valid);
      end
      check("rstmid.no_activity", wren_seen, 0);
      check("rstmid.ready", {31'd0, req_ready}, 32'd1);
      check("rstmid.mem_word", mem[8'h80], 32'h1234_55EF);

      // Back-to-back with req_valid held high
      seq[0] = '{1'b0, F3_W,  32'h100, 32'd0,         5'd21, 32'h8081_7F80, 1'b0, 2 + LAT};
      seq[1] = '{1'b1, F3_W,  32'h300, 32'h1122_3344, 5'd22, 32'd0,         1'b0, 2};
      seq[2] = '{1'b0, F3_BU, 32'h101, 32'd0,         5'd23, 32'h0000_007F, 1'b0, 2 + LAT};
      seq[3] = '{1'b0, F3_W,  32'h302, 32'd0,         5'd24, 32'd0,         1'b1, 1};
      seq[4] = '{1'b1, F3_B,  32'h300, 32'h0000_0099, 5'd25, 32'd0,         1'b0, 3 + LAT};
      seq[5] = '{1'b0, F3_W,  32'h300, 32'd0,         5'd26, 32'h1122_3399, 1'b0, 2 + LAT};
      idx        = 0;
      nresp      = 0;
      cyc        = 0;
      next_acc   = -1;
      req_valid  = 1'b1;
      req_we     = seq[0].we;
      req_funct3 = seq[0].f3;
      req_addr   = seq[0].addr;
      req_wdata  = seq[0].wdata;
      req_rd     = seq[0].rd;
      while (nresp < 6 && cyc < 200) begin
         was_acc = req_valid && req_ready;
         @(posedge clk); #1;
         cyc++;
         if (was_acc) begin
            if (next_acc >= 0) check("b2b.accept_cycle", cyc, next_acc);
            sb.push_back('{rd: seq[idx].rd, rdata: seq[idx].rdata, fault: seq[idx].fault,
                           lat: cyc + seq[idx].lat - 1});
            next_acc = cyc + seq[idx].lat + 1;
            idx++;
            if (idx < 6) begin
               req_we     = seq[idx].we;
               req_funct3 = seq[idx].f3;
               req_addr   = seq[idx].addr;
               req_wdata  = seq[idx].wdata;
               req_rd     = seq[idx].rd;
            end else begin
               req_valid = 1'b0;
            end
         end
         if (resp_valid) begin
            check("b2b.sb_nonempty", sb.size(), (sb.size() > 0) ? sb.size() : 1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("b2b.resp_cycle", cyc, e.lat);
               check("b2b.rd",    {27'd0, resp_rd}, {27'd0, e.rd});
               check("b2b.rdata", resp_rdata, e.rdata);
               check("b2b.fault", {31'd0, resp_fault}, {31'd0, e.fault});
            end
            nresp++;
         end
      end
      req_valid = 1'b0;
      check("b2b.responses", nresp, 6);
      check("b2b.accepts", idx, 6);
      @(posedge clk); #1;
`ifdef LSU_PERF_CNT_EN
      check("perf.loads",  perf_loads,  32'd3);
      check("perf.stores", perf_stores, 32'd2);
      check("perf.faults", perf_faults, 32'd1);
`else
      check("perf.loads",  perf_loads,  32'd0);
      check("perf.stores", perf_stores, 32'd0);
      check("perf.faults", perf_faults, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
